axi_arbiter: RTL

AXI_ARBITER -- requirements
Module: axi_arbiter

---
 rtl/axi_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/axi_arbiter.sv
// Two-master AXI arbiter: instruction and data caches share one read port
// (data cache wins ties); data-cache writes pass straight through.
module axi_arbiter #(
    parameter logic [3:0] ID_I = 4'd0,
    parameter logic [3:0] ID_D = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,
    // instruction cache
    input  logic [31:0] i_araddr,
    input  logic [7:0]  i_arlen,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    output logic        i_rvalid,
    input  logic        i_rready,
    // data cache
    input  logic [31:0] d_araddr,
    input  logic [7:0]  d_arlen,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic [31:0] d_rdata,
    output logic        d_rlast,
    output logic        d_rvalid,
    input  logic        d_rready,
    input  logic [31:0] d_awaddr,
    input  logic [7:0]  d_awlen,
    input  logic [2:0]  d_awsize,
    input  logic        d_awvalid,
    output logic        d_awready,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    input  logic        d_wlast,
    input  logic        d_wvalid,
    output logic        d_wready,
    output logic        d_bvalid,
    input  logic        d_bready,
    // AXI master
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    logic [1:0] state_q, state_d;
    logic       gnt_dc_q, gnt_dc_d; // 1: data cache owns the read port
    logic       in_addr, in_data;

    always_comb begin
        state_d  = state_q;
        gnt_dc_d = gnt_dc_q;
        case (state_q)
            R_IDLE: begin
                if (d_arvalid) begin
                    gnt_dc_d = 1'b1;
                    state_d  = R_ADDR;
                end else if (i_arvalid) begin
                    gnt_dc_d = 1'b0;
                    state_d  = R_ADDR;
                end
            end
            R_ADDR:  if (arready) state_d = R_DATA;
            R_DATA:  if (rvalid && rready && rlast) state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= R_IDLE;
            gnt_dc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_dc_q <= gnt_dc_d;
        end
    end

    assign in_addr = (state_q == R_ADDR);
    assign in_data = (state_q == R_DATA);

    assign arvalid   = in_addr;
    assign araddr    = gnt_dc_q ? d_araddr : i_araddr;
    assign arlen     = gnt_dc_q ? d_arlen : i_arlen;
    assign arid      = gnt_dc_q ? ID_D : ID_I;
    assign arsize    = 3'b010;
    assign arburst   = 2'b01;
    assign i_arready = in_addr && !gnt_dc_q && arready;
    assign d_arready = in_addr && gnt_dc_q && arready;

    // Read data fans out to both caches; only the granted side sees rvalid.
    assign i_rdata  = rdata;
    assign i_rlast  = rlast;
    assign d_rdata  = rdata;
    assign d_rlast  = rlast;
    assign i_rvalid = in_data && !gnt_dc_q && rvalid;
    assign d_rvalid = in_data && gnt_dc_q && rvalid;
    assign rready   = in_data && (gnt_dc_q ? d_rready : i_rready);

    assign awid      = ID_D;
    assign awaddr    = d_awaddr;
    assign awlen     = d_awlen;
    assign awsize    = d_awsize;
    assign awburst   = 2'b01;
    assign awvalid   = d_awvalid;
    assign d_awready = awready;
    assign wid       = ID_D;
    assign wdata     = d_wdata;
    assign wstrb     = d_wstrb;
    assign wlast     = d_wlast;
    assign wvalid    = d_wvalid;
    assign d_wready  = wready;
    assign d_bvalid  = bvalid;
    assign bready    = d_bready;

    // Response IDs and codes carry no information for this single-ID port.
    logic unused_resp;
    assign unused_resp = ^{rid, rresp, bid, bresp};
endmodule
